muldiv_ctrl: RTL and testbench

Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO operations of the EXE stage. It owns the architectural HI/LO registers and runs a counted multiply and a 32-step iterative restoring divider. While busy, it stalls any younger consumer of HI/LO. It sits beside the EXE ALU, takes operands after EXE forwarding, and honours the same mispredict/flush squash as the EXE pipeline register.

---
 rtl/muldiv_ctrl.sv | 172 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// EXE-stage HI/LO sequencer: counted multiply, 32-step restoring divide, MTHI/MTLO.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU raise illegal_op.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_STEPS  = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        hilo_read,
    input  logic        mispredict,
    input  logic        flush_fCOM,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        illegal_op
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_MAX = (MUL_CYCLES > DIV_STEPS) ? MUL_CYCLES : DIV_STEPS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
    typedef enum logic [0:0] {IDLE, MUL} state_t;
`endif

    state_t            state, state_next;
    logic [CNT_W-1:0]  count;
    logic [63:0]       product;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic              squash;

`ifdef MULDIV_DIV_EN
    logic [31:0]       quot;
    logic [31:0]       rem;
    logic [31:0]       divisor;
    logic              q_neg;
    logic              r_neg;
    logic [32:0]       shifted;
    logic [32:0]       diff;

    assign shifted = {rem, quot[31]};
    assign diff    = shifted - {1'b0, divisor};
`endif

    assign squash = mispredict | flush_fCOM;
    assign prod_s = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
    assign prod_u = {32'b0, opA} * {32'b0, opB};
    assign busy   = (state != IDLE);
    assign stall  = busy & (start | hilo_read);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (squash) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (op == OP_MULT || op == OP_MULTU))
                        state_next = MUL;
`ifdef MULDIV_DIV_EN
                    else if (start && (op == OP_DIV || op == OP_DIVU))
                        state_next = DIV;
`endif
                end
                MUL:     if (count == '0) state_next = IDLE;
`ifdef MULDIV_DIV_EN
                DIV:     if (count == '0) state_next = FIX;
                FIX:     state_next = IDLE;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    // A squash blocks every datapath update, so HI/LO and done are untouched that cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count      <= '0;
            product    <= '0;
            HI         <= '0;
            LO         <= '0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
`ifdef MULDIV_DIV_EN
            quot       <= '0;
            rem        <= '0;
            divisor    <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            if (!squash) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT: begin
                                    product <= prod_s;
                                    count   <= CNT_W'(MUL_CYCLES - 1);
                                end
                                OP_MULTU: begin
                                    product <= prod_u;
                                    count   <= CNT_W'(MUL_CYCLES - 1);
                                end
                                OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                                    quot    <= (op == OP_DIV && opA[31]) ? -opA : opA;
                                    divisor <= (op == OP_DIV && opB[31]) ? -opB : opB;
                                    rem     <= '0;
                                    // Divide-by-zero keeps the all-ones quotient unsigned.
                                    q_neg   <= (op == OP_DIV) & (opA[31] ^ opB[31]) & (|opB);
                                    r_neg   <= (op == OP_DIV) & opA[31];
                                    count   <= CNT_W'(DIV_STEPS - 1);
`else
                                    illegal_op <= 1'b1;
`endif
                                end
                                OP_MTHI: HI <= opA;
                                OP_MTLO: LO <= opA;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (count == '0) begin
                            {HI, LO} <= product;
                            done     <= 1'b1;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
`ifdef MULDIV_DIV_EN
                    DIV: begin
                        rem  <= diff[32] ? shifted[31:0] : diff[31:0];
                        quot <= {quot[30:0], ~diff[32]};
                        if (count != '0) count <= count - 1'b1;
                    end
                    FIX: begin
                        LO   <= q_neg ? -quot : quot;
                        HI   <= r_neg ? -rem : rem;
                        done <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, random ops against an arithmetic model,
// and hand-written multi-cycle sequences. Divide checks adapt to MULDIV_DIV_EN.
module tb_muldiv_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        hilo_read;
    logic        mispredict;
    logic        flush_fCOM;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        illegal_op;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_STEPS(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .op         (op),
        .opA        (opA),
        .opB        (opB),
        .hilo_read  (hilo_read),
        .mispredict (mispredict),
        .flush_fCOM (flush_fCOM),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .HI         (HI),
        .LO         (LO),
        .illegal_op (illegal_op)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of one op, straight from signed/unsigned arithmetic.
    function automatic logic [63:0] expect_hilo(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV, OP_DIVU: begin
`ifndef MULDIV_DIV_EN
                return {model_hi, model_lo};
`else
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == OP_DIVU) return {a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
`endif
            end
            OP_MTHI:  return {a, model_lo};
            OP_MTLO:  return {model_hi, a};
            default:  return {model_hi, model_lo};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o);
        if (o == OP_MULT || o == OP_MULTU) return MUL_CYCLES;
`ifdef MULDIV_DIV_EN
        if (o == OP_DIV || o == OP_DIVU) return 33;
`endif
        return 0;
    endfunction

    // Issue one op in cycle T and follow it through busy, done and the cycle after.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] eh, input logic [31:0] el, input bit hold_read);
        int lat;
        bit is_illegal;
        lat = latency(o);
        is_illegal = 1'b0;
`ifndef MULDIV_DIV_EN
        is_illegal = (o == OP_DIV || o == OP_DIVU);
`endif
        start = 1'b1; op = o; opA = a; opB = b; hilo_read = hold_read;
        #1;
        check_output($sformatf("stall_idle_op%0d", o), {31'b0, stall}, 32'd0);
        tick();
        start = 1'b0; opA = $urandom; opB = $urandom;
        if (lat > 0) begin
            for (int k = 1; k <= lat; k++) begin
                #1;
                check_output($sformatf("busy_op%0d_c%0d", o, k), {31'b0, busy}, 32'd1);
                check_output($sformatf("done_early_op%0d_c%0d", o, k), {31'b0, done}, 32'd0);
                if (hold_read)
                    check_output($sformatf("stall_busy_op%0d_c%0d", o, k), {31'b0, stall}, 32'd1);
                tick();
            end
            #1;
            check_output($sformatf("busy_end_op%0d", o), {31'b0, busy}, 32'd0);
            check_output($sformatf("done_op%0d", o), {31'b0, done}, 32'd1);
            check_output($sformatf("stall_done_op%0d", o), {31'b0, stall}, 32'd0);
            check_output($sformatf("hi_op%0d", o), HI, eh);
            check_output($sformatf("lo_op%0d", o), LO, el);
            hilo_read = 1'b0;
            tick();
            #1;
            check_output($sformatf("done_pulse_op%0d", o), {31'b0, done}, 32'd0);
        end else begin
            #1;
            check_output($sformatf("illegal_op%0d", o), {31'b0, illegal_op}, {31'b0, is_illegal});
            check_output($sformatf("busy_short_op%0d", o), {31'b0, busy}, 32'd0);
            check_output($sformatf("done_short_op%0d", o), {31'b0, done}, 32'd0);
            check_output($sformatf("hi_short_op%0d", o), HI, eh);
            check_output($sformatf("lo_short_op%0d", o), LO, el);
            hilo_read = 1'b0;
            tick();
            #1;
            check_output($sformatf("illegal_pulse_op%0d", o), {31'b0, illegal_op}, 32'd0);
        end
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] res2;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          saw_done;
        logic [31:0] edge_vals [6];

        vecs.push_back('{op: OP_MULT,  a: 32'hFFFF_FFFF, b: 32'h2,         exp_hi: 32'hFFFF_FFFF, exp_lo: 32'hFFFF_FFFE});
        vecs.push_back('{op: OP_MULTU, a: 32'hFFFF_FFFF, b: 32'h2,         exp_hi: 32'h0000_0001, exp_lo: 32'hFFFF_FFFE});
        vecs.push_back('{op: OP_MULT,  a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, exp_hi: 32'h3FFF_FFFF, exp_lo: 32'h0000_0001});
        vecs.push_back('{op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'h2,         exp_hi: 32'hFFFF_FFFF, exp_lo: 32'hFFFF_FFFD});
        vecs.push_back('{op: OP_DIVU,  a: 32'd100,       b: 32'd7,         exp_hi: 32'h0000_0002, exp_lo: 32'h0000_000E});
        vecs.push_back('{op: OP_DIVU,  a: 32'd5,         b: 32'd0,         exp_hi: 32'h0000_0005, exp_lo: 32'hFFFF_FFFF});
        vecs.push_back('{op: OP_DIV,   a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp_hi: 32'h0000_0000, exp_lo: 32'h8000_0000});
        vecs.push_back('{op: OP_MULTU, a: 32'h0001_0000, b: 32'h0001_0000, exp_hi: 32'h0000_0001, exp_lo: 32'h0000_0000});

        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF; edge_vals[4] = 32'h0000_0001; edge_vals[5] = 32'h0000_0007;

        RESET = 1'b0; start = 1'b0; op = 3'd0; opA = '0; opB = '0;
        hilo_read = 1'b1; mispredict = 1'b0; flush_fCOM = 1'b0;
        model_hi = '0; model_lo = '0;
        #12;
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_stall", {31'b0, stall}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_illegal", {31'b0, illegal_op}, 32'd0);
        check_output("rst_hi", HI, 32'd0);
        check_output("rst_lo", LO, 32'd0);
        hilo_read = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            if (latency(vecs[i].op) == 0 && (vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU))
                apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, model_hi, model_lo, 1'b1);
            else
                apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b1);
        end

        $display("[TB] MTHI after MULT");
        apply_stimulus(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        apply_stimulus(OP_MTHI, 32'h1234, 32'd0, 32'h1234, 32'd15, 1'b0);
        apply_stimulus(OP_MTLO, 32'hABCD_0001, 32'd0, 32'h1234, 32'hABCD_0001, 1'b0);

        $display("[TB] second start during MUL");
        res  = expect_hilo(OP_MULT, 32'h0001_0003, 32'hFFFF_FFF9);
        res2 = expect_hilo(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b1; op = OP_MULT; opA = 32'h0001_0003; opB = 32'hFFFF_FFF9;
        tick();
        start = 1'b0;
        #1;
        check_output("b2b_busy1", {31'b0, busy}, 32'd1);
        tick();
        start = 1'b1; op = OP_MULTU; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF;
        for (int k = 2; k <= MUL_CYCLES; k++) begin
            #1;
            check_output($sformatf("b2b_stall_c%0d", k), {31'b0, stall}, 32'd1);
            tick();
        end
        #1;
        check_output("b2b_stall_idle", {31'b0, stall}, 32'd0);
        check_output("b2b_done1", {31'b0, done}, 32'd1);
        check_output("b2b_hi1", HI, res[63:32]);
        check_output("b2b_lo1", LO, res[31:0]);
        tick();
        start = 1'b0;
        for (int k = 1; k <= MUL_CYCLES; k++) begin
            #1;
            check_output($sformatf("b2b_busy2_c%0d", k), {31'b0, busy}, 32'd1);
            tick();
        end
        #1;
        check_output("b2b_done2", {31'b0, done}, 32'd1);
        check_output("b2b_hi2", HI, res2[63:32]);
        check_output("b2b_lo2", LO, res2[31:0]);
        model_hi = res2[63:32];
        model_lo = res2[31:0];
        tick();

        $display("[TB] squash during MUL and with start");
        start = 1'b1; op = OP_MULT; opA = 32'd9; opB = 32'd9;
        tick();
        start = 1'b0;
        tick();
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        #1;
        check_output("sq_mul_busy", {31'b0, busy}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check_output("sq_mul_nodone", {31'b0, saw_done}, 32'd0);
        check_output("sq_mul_hi", HI, model_hi);
        check_output("sq_mul_lo", LO, model_lo);
        start = 1'b1; op = OP_MTHI; opA = 32'hBEEF_0000; mispredict = 1'b1;
        tick();
        op = OP_MULT; mispredict = 1'b0; flush_fCOM = 1'b1;
        #1;
        check_output("sq_mthi_hi", HI, model_hi);
        tick();
        start = 1'b0; flush_fCOM = 1'b0;
        #1;
        check_output("sq_start_busy", {31'b0, busy}, 32'd0);

`ifdef MULDIV_DIV_EN
        $display("[TB] flush in 10th DIV cycle");
        start = 1'b1; op = OP_DIV; opA = 32'd1000; opB = 32'd3;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        flush_fCOM = 1'b1;
        #1;
        check_output("fl_div_busy_before", {31'b0, busy}, 32'd1);
        tick();
        flush_fCOM = 1'b0;
        #1;
        check_output("fl_div_busy", {31'b0, busy}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check_output("fl_div_nodone", {31'b0, saw_done}, 32'd0);
        check_output("fl_div_hi", HI, model_hi);
        check_output("fl_div_lo", LO, model_lo);
`endif

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            res = expect_hilo(rop, ra, rb);
            apply_stimulus(rop, ra, rb, res[63:32], res[31:0], 1'($urandom_range(0, 1)));
        end

        $display("[TB] asynchronous reset mid-operation");
        apply_stimulus(OP_MTLO, 32'hDEAD_0001, 32'd0, model_hi, 32'hDEAD_0001, 1'b0);
        start = 1'b1; opA = 32'd77; opB = 32'd5;
`ifdef MULDIV_DIV_EN
        op = OP_DIV;
`else
        op = OP_MULT;
`endif
        tick();
        start = 1'b0; hilo_read = 1'b1;
        tick();
        tick();
        #2;
        RESET = 1'b0;
        #1;
        check_output("arst_hi", HI, 32'd0);
        check_output("arst_lo", LO, 32'd0);
        check_output("arst_busy", {31'b0, busy}, 32'd0);
        check_output("arst_stall", {31'b0, stall}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1; hilo_read = 1'b0;
        model_hi = '0; model_lo = '0;
        tick();
        #1;
        check_output("arst_after_busy", {31'b0, busy}, 32'd0);
        check_output("arst_after_done", {31'b0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
